lsu_store_sequencer: RTL
========================

// Module: lsu_store_sequencer
// PURPOSE
//  Sequences LSU store requests into the byte-enabled word register bank.
//  Takes byte/half/word stores at any byte address and emits word-aligned
//  write beats with per-lane byte enables and lane-shifted data.
//  A store that crosses a word boundary is split into two consecutive beats.
//  Sits between the LSU request path and the storage registers.
// PARAMETERS
//  ADDR_W  12  byte-address width; word address width is ADDR_W-2 (ADDR_W>=3)
// PORTS
//  clk        in   1         clock, all state on posedge
//  rst        in   1         synchronous, active-high reset
//  req_valid  in   1         store request valid
//  req_ready  out  1         sequencer can accept a request
//  req_addr   in   ADDR_W    byte address
//  req_size   in   2         00 byte, 01 half, 10 word, 11 illegal
//  req_wdata  in   32        store data, right-aligned (LSBs used)
//  wr_en      out  1         write beat valid this cycle
//  wr_addr    out  ADDR_W-2  word address of beat
//  wr_be      out  4         byte-lane enables, bit i = bits [8i+7:8i]
//  wr_data    out  32        lane-aligned write data
//  done       out  1         1-cycle pulse on the last beat of a store
//  err        out  1         1-cycle pulse for an illegal-size request
// BEHAVIOUR
//  - Single clock domain (clk). Reset is synchronous and active-high (rst).
//  - States: IDLE, LO, HI, ERR. Moore outputs decoded from registered state/ctx.
//  - Reset: state=IDLE, ctx cleared. wr_en=0, wr_be=0, wr_data=0, wr_addr=0,
//    done=0, err=0. req_ready=0 while rst=1.
//  - IDLE: req_ready=1. Handshake is valid&ready.
//  - On accept at edge T, latch addr, size and data. Then:
//    off=addr[1:0], n=1/2/4 bytes.
//    mask8 = ((1<<n)-1) << off  (8 bits).
//    sh64  = {32'b0,wdata masked to n bytes} << (8*off).
//    Size 11 goes to ERR. Every other size goes to LO.
//  - LO (cycle T+1): wr_en=1, wr_addr=addr[ADDR_W-1:2],
//    wr_be=mask8[3:0], wr_data=sh64[31:0].
//    If mask8[7:4]==0: done=1, next IDLE. Otherwise next HI.
//  - HI (cycle T+2): wr_en=1, wr_addr=word addr+1 mod 2^(ADDR_W-2)
//    (wraps to 0), wr_be=mask8[7:4], wr_data=sh64[63:32], done=1, next IDLE.
//  - ERR (T+1): err=1, wr_en=0, next IDLE. No register write ever occurs.
//  - When wr_en=0: wr_be=0, wr_data=0, wr_addr=0.
//  - Data bytes beyond the size are ignored; unused lanes of wr_data are 0.
//  - req_ready=0 in LO/HI/ERR. Requests are not queued.
//    Aligned throughput is 1 store per 2 cycles; a split store takes 3 cycles.
//  - Reset mid-operation (LO/HI/ERR): the pending beat or err is dropped.
//    The cycle after rst shows all outputs 0. IDLE resumes after rst falls.
//  - req_addr/size/wdata may change freely while req_ready=0.
// TESTING
//  1 word @0x010, data 0xDEADBEEF: one beat, wr_addr=0x004, be=1111,
//    data=0xDEADBEEF, done in the same cycle.
//  2 byte @0x013, data 0x123456AB: one beat, addr=0x004, be=1000,
//    data=0xAB000000.
//  3 word @0x006, data 0x11223344:
//    beat1 addr=0x001 be=1100 data=0x33440000;
//    beat2 addr=0x002 be=0011 data=0x00001122, done on beat2.
//  4 half @0xFFF (ADDR_W=12), data 0xBEEF:
//    beat1 addr=0x3FF be=1000 data=0xEF000000;
//    beat2 addr=0x000 be=0001 data=0x000000BE.
//  5 size=11 @0x020: no wr_en, err=1 at T+1, req_ready=1 at T+2.
//  6 case 3 with rst=1 during beat1: no beat2, all outputs 0 next cycle,
//    req_ready=1 the cycle after rst=0. Back-to-back valid: no request lost.

Source files
------------

// File: rtl/lsu_store_sequencer.sv
// -----------------------------------------------------------------------------
// lsu_store_sequencer
//
// Purpose:
//   Converts LSU byte/half/word stores at arbitrary byte addresses into
//   word-aligned write beats for the byte-enabled word register bank.
//   Each beat carries per-lane byte enables and lane-shifted data. A store
//   that straddles a word boundary is emitted as two consecutive beats
//   (low word first, then the next word, wrapping at the top of the space).
//
// Ports:
//   clk        in   1         clock, all state on posedge
//   rst        in   1         synchronous active-high reset
//   req_valid  in   1         store request valid
//   req_ready  out  1         sequencer can accept a request (IDLE only)
//   req_addr   in   ADDR_W    byte address
//   req_size   in   2         00 byte, 01 half, 10 word, 11 illegal
//   req_wdata  in   32        store data, right-aligned
//   wr_en      out  1         write beat valid this cycle
//   wr_addr    out  ADDR_W-2  word address of the beat
//   wr_be      out  4         byte-lane enables
//   wr_data    out  32        lane-aligned write data
//   done       out  1         pulse on the last beat of a store
//   err        out  1         pulse for an illegal-size request
// -----------------------------------------------------------------------------
module lsu_store_sequencer #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic [31:0]       req_wdata,
    output logic              wr_en,
    output logic [ADDR_W-3:0] wr_addr,
    output logic [3:0]        wr_be,
    output logic [31:0]       wr_data,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    // Context captured at accept: word address, 8-bit lane mask spanning two
    // words, and the 64-bit lane-shifted data for both beats.
    logic [ADDR_W-3:0] r_waddr;
    logic [7:0]        r_mask;
    logic [63:0]       r_sh;

    logic              w_accept;
    logic [3:0]        w_base;
    logic [31:0]       w_masked;
    logic [7:0]        w_mask8;
    logic [63:0]       w_sh64;

    assign w_accept = req_valid & req_ready;

    // Unshifted lane enables for the request size; the illegal size yields
    // no lanes, though it never reaches a beat state anyway.
    always_comb begin
        w_base = 4'b0000;
        case (req_size)
            2'b00:   w_base = 4'b0001;
            2'b01:   w_base = 4'b0011;
            2'b10:   w_base = 4'b1111;
            default: w_base = 4'b0000;
        endcase
    end

    // Zero the data bytes beyond the store size so unused lanes read 0.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane_mask
            assign w_masked[8*gi +: 8] = w_base[gi] ? req_wdata[8*gi +: 8] : 8'h00;
        end
    endgenerate

    assign w_mask8 = {4'b0000, w_base} << req_addr[1:0];
    assign w_sh64  = {32'h0, w_masked} << {req_addr[1:0], 3'b000};

    // State and context registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_waddr <= '0;
            r_mask  <= '0;
            r_sh    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_waddr <= req_addr[ADDR_W-1:2];
                r_mask  <= w_mask8;
                r_sh    <= w_sh64;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = (req_size == 2'b11) ? S_ERR : S_LO;
                end
            end
            S_LO:    w_state_next = (r_mask[7:4] == 4'b0000) ? S_IDLE : S_HI;
            S_HI:    w_state_next = S_IDLE;
            S_ERR:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Moore outputs decoded from registered state/context. Holding every
    // output low while rst is high drops any beat or error in flight.
    always_comb begin
        req_ready = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_be     = 4'b0000;
        wr_data   = 32'h0;
        done      = 1'b0;
        err       = 1'b0;
        if (!rst) begin
            case (r_state)
                S_IDLE: req_ready = 1'b1;
                S_LO: begin
                    wr_en   = 1'b1;
                    wr_addr = r_waddr;
                    wr_be   = r_mask[3:0];
                    wr_data = r_sh[31:0];
                    done    = (r_mask[7:4] == 4'b0000);
                end
                S_HI: begin
                    wr_en   = 1'b1;
                    // Natural wrap of the word address at the top of the space.
                    wr_addr = r_waddr + {{(ADDR_W-3){1'b0}}, 1'b1};
                    wr_be   = r_mask[7:4];
                    wr_data = r_sh[63:32];
                    done    = 1'b1;
                end
                S_ERR:   err = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
